// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command controller and the board: serial line in,
// controlled outputs and receive/error status out.
interface uart_cmd_ctrl_if #(
  parameter int unsigned NUM_OUT = 4
);
  logic               serial_rx;
  logic [NUM_OUT-1:0] out;
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               frame_err;
  logic               parity_err;
  logic               cmd_err;
  logic               busy;

  modport master (
    input  serial_rx,
    output out, rx_byte, rx_valid, frame_err, parity_err, cmd_err, busy
  );

  modport slave (
    output serial_rx,
    input  out, rx_byte, rx_valid, frame_err, parity_err, cmd_err, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART receiver plus opcode/channel decoder driving NUM_OUT set/clear/toggle outputs.
// Define UART_CMD_PARITY_EN for start + 8 data + even parity + stop framing.
module uart_cmd_ctrl #(
  parameter int unsigned        CLK_FREQ_HZ = 33330000,
  parameter int unsigned        BAUD_RATE   = 115200,
  parameter int unsigned        NUM_OUT     = 4,
  parameter logic [NUM_OUT-1:0] OUT_RESET   = '0
) (
  input logic             clk,
  input logic             rst,
  uart_cmd_ctrl_if.master bus
);

  localparam int unsigned      CPB      = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned      HALF     = CPB / 2;
  localparam int unsigned      CNT_W    = $clog2(CPB) + 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CPB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_CMD_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state_q, state_n;
  logic               rx_meta, rx_sync;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_clr;
  logic [2:0]         bit_q, bit_n;
  logic [7:0]         shift_q, shift_n;
  logic               valid_n, ferr_n;
  logic [7:0]         rx_byte_q;
  logic               rx_valid_q, frame_err_q, busy_q;
  logic [NUM_OUT-1:0] out_q, out_n;
  logic               cmd_err_q, cmd_err_n;
`ifdef UART_CMD_PARITY_EN
  logic               par_bad_q, par_bad_n;
  logic               perr_n, parity_err_q;
`endif

  // Two-flop synchroniser; idle-high reset avoids a false start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.serial_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_CMD_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      bit_q   <= bit_n;
      shift_q <= shift_n;
`ifdef UART_CMD_PARITY_EN
      par_bad_q <= par_bad_n;
`endif
    end
  end

  // Receive FSM: mid-bit sampling referenced to the synchronised start edge
  always_comb begin
    state_n = state_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_CMD_PARITY_EN
    par_bad_n = par_bad_q;
    perr_n    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync) state_n = S_START;
      end
      S_START: begin
        bit_n = '0;
        if (cnt_q == CNT_HALF) state_n = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_n = {rx_sync, shift_q[7:1]};
          bit_n   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_CMD_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          par_bad_n = rx_sync ^ (^shift_q);
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_sync) begin
            state_n = S_IDLE;
`ifdef UART_CMD_PARITY_EN
            if (par_bad_q) perr_n = 1'b1;
            else           valid_n = 1'b1;
`else
            valid_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bit timer restarts on every state change and after each data sample
  assign cnt_clr = (state_n != state_q) || ((state_q == S_DATA) && (cnt_q == CNT_FULL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_CMD_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (valid_n) rx_byte_q <= shift_q;
      rx_valid_q  <= valid_n;
      frame_err_q <= ferr_n;
      busy_q      <= (state_n != S_IDLE);
`ifdef UART_CMD_PARITY_EN
      parity_err_q <= perr_n;
`endif
    end
  end

  // Command decode: opcode in [7:6], channel index in [5:0]
  always_comb begin
    out_n     = out_q;
    cmd_err_n = 1'b0;
    if (rx_valid_q) begin
      cmd_err_n = ({26'd0, rx_byte_q[5:0]} >= NUM_OUT);
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (rx_byte_q[5:0] == 6'(i)) begin
          case (rx_byte_q[7:6])
            2'b01:   out_n[i] = 1'b1;
            2'b10:   out_n[i] = 1'b0;
            2'b11:   out_n[i] = ~out_q[i];
            default: out_n[i] = out_q[i];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= OUT_RESET;
      cmd_err_q <= 1'b0;
    end else begin
      out_q     <= out_n;
      cmd_err_q <= cmd_err_n;
    end
  end

  assign bus.out       = out_q;
  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.busy      = busy_q;
`ifdef UART_CMD_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed command table, line-fault sequences and random
// frames checked against a byte-level command model.
module tb_uart_cmd_ctrl;

  localparam int         CPB     = 10;
  localparam logic [3:0] OUT_RST = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.NUM_OUT(4)) bus ();

  uart_cmd_ctrl #(
    .CLK_FREQ_HZ(1000000),
    .BAUD_RATE  (100000),
    .NUM_OUT    (4),
    .OUT_RESET  (OUT_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_out;
    logic       exp_cerr;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_cerr = 0;
  int exp_valid = 0, exp_ferr = 0, exp_perr = 0;

  logic [3:0] exp_out = OUT_RST;
  logic [7:0] exp_q[$];
  logic [7:0] mon_b;
  bit         pend      = 1'b0;
  bit         pend_cerr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: each accepted byte is a whole command applied to a 4-bit output vector
  task automatic model_apply(input logic [7:0] b);
    int idx;
    idx = int'(b[5:0]);
    pend = 1'b1;
    pend_cerr = (idx >= 4);
    if (idx < 4) begin
      case (b[7:6])
        2'b01:   exp_out[idx] = 1'b1;
        2'b10:   exp_out[idx] = 1'b0;
        2'b11:   exp_out[idx] = ~exp_out[idx];
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_out = OUT_RST;
      exp_q.delete();
      pend = 1'b0;
    end else begin
      chk("out_track", 64'(bus.out), 64'(exp_out));
      chk("cmd_err_track", 64'(bus.cmd_err), pend ? 64'(pend_cerr) : 64'd0);
      pend = 1'b0;
      chk("pulse_onehot", 64'($countones({bus.rx_valid, bus.frame_err, bus.parity_err}) <= 1), 64'd1);
      if (bus.cmd_err)    n_cerr++;
      if (bus.frame_err)  n_ferr++;
      if (bus.parity_err) n_perr++;
      if (exp_q.size() == 0) begin
        chk("rx_valid_unexpected", 64'(bus.rx_valid), 64'd0);
      end else if (bus.rx_valid) begin
        mon_b = exp_q.pop_front();
        chk("rx_byte", 64'(bus.rx_byte), 64'(mon_b));
        model_apply(mon_b);
      end
      if (bus.rx_valid) n_valid++;
    end
  end

  // Drive one frame; stops early after 'limit' clock cycles when limit > 0
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                             input int limit, input bit good);
    logic [11:0] fr;
    int nb;
    int n;
    fr    = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
`ifdef UART_CMD_PARITY_EN
    fr[9]  = (^d) ^ bad_par;
    fr[10] = stop_bit;
    nb = 11;
`else
    fr[9] = stop_bit;
    nb = 10;
`endif
    if (good) begin
      exp_q.push_back(d);
      exp_valid++;
    end else if (limit == 0 && !stop_bit) begin
      exp_ferr++;
    end else if (limit == 0 && bad_par) begin
      exp_perr++;
    end
    n = 0;
    for (int k = 0; k < nb; k++) begin
      bus.serial_rx = fr[k];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        n++;
        if (limit > 0 && n >= limit) return;
      end
    end
    bus.serial_rx = 1'b1;
  endtask

  vec_t tbl[8];
  int v0, f0, p0, c0;
  logic [7:0] rd;
  logic       rbad;

  initial begin
    tbl[0] = '{8'h41, 4'b1010, 1'b0};
    tbl[1] = '{8'hC3, 4'b0010, 1'b0};
    tbl[2] = '{8'hC3, 4'b1010, 1'b0};
    tbl[3] = '{8'h80, 4'b1010, 1'b0};
    tbl[4] = '{8'h45, 4'b1010, 1'b1};
    tbl[5] = '{8'h02, 4'b1010, 1'b0};
    tbl[6] = '{8'h3F, 4'b1010, 1'b1};
    tbl[7] = '{8'hC0, 4'b1011, 1'b0};

    bus.serial_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(bus.out), 64'(OUT_RST));
    chk("rst_rx_byte", 64'(bus.rx_byte), 64'd0);
    chk("rst_pulses", 64'({bus.rx_valid, bus.frame_err, bus.parity_err, bus.cmd_err}), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Back-to-back command table
    for (int i = 0; i < 8; i++) begin
      c0 = n_cerr;
      v0 = n_valid;
      drive_frame(tbl[i].data, 1'b1, 1'b0, 0, 1'b1);
      chk($sformatf("tbl%0d_out", i), 64'(bus.out), 64'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_cmd_err", i), 64'(n_cerr - c0), 64'(tbl[i].exp_cerr));
      chk($sformatf("tbl%0d_valid", i), 64'(n_valid - v0), 64'd1);
    end
    chk("tbl_rx_byte_hold", 64'(bus.rx_byte), 64'hC0);

    // Stop bit low followed by a long break
    v0 = n_valid;
    f0 = n_ferr;
    drive_frame(8'h41, 1'b0, 1'b0, 0, 1'b0);
    bus.serial_rx = 1'b0;
    repeat (50 * CPB) @(negedge clk);
    chk("break_ferr", 64'(n_ferr - f0), 64'd1);
    chk("break_valid", 64'(n_valid - v0), 64'd0);
    chk("break_busy", 64'(bus.busy), 64'd1);
    bus.serial_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break_exit_busy", 64'(bus.busy), 64'd0);
    drive_frame(8'h42, 1'b1, 1'b0, 0, 1'b1);
    chk("after_break_out", 64'(bus.out), 64'b1111);

    // Short low glitch in idle
    v0 = n_valid;
    f0 = n_ferr;
    bus.serial_rx = 1'b0;
    repeat (3) @(negedge clk);
    bus.serial_rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_start", 64'(bus.busy), 64'd1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_end", 64'(bus.busy), 64'd0);
    chk("glitch_pulses", 64'((n_valid - v0) + (n_ferr - f0)), 64'd0);

    // Reset in the middle of data bit 4
    drive_frame(8'hC1, 1'b1, 1'b0, 5 * CPB + CPB / 2, 1'b0);
    rst = 1'b1;
    bus.serial_rx = 1'b1;
    @(negedge clk);
    chk("midrst_out", 64'(bus.out), 64'(OUT_RST));
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_rx_byte", 64'(bus.rx_byte), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v0 = n_valid;
    f0 = n_ferr;
    repeat (3 * CPB) @(negedge clk);
    chk("midrst_quiet", 64'((n_valid - v0) + (n_ferr - f0)), 64'd0);
    drive_frame(8'h40, 1'b1, 1'b0, 0, 1'b1);
    chk("midrst_next_out", 64'(bus.out), 64'b1001);

`ifdef UART_CMD_PARITY_EN
    // Parity mismatch then a clean retry
    v0 = n_valid;
    p0 = n_perr;
    drive_frame(8'h41, 1'b1, 1'b1, 0, 1'b0);
    chk("par_bad_perr", 64'(n_perr - p0), 64'd1);
    chk("par_bad_valid", 64'(n_valid - v0), 64'd0);
    chk("par_bad_out", 64'(bus.out), 64'b1001);
    chk("par_bad_rx_byte", 64'(bus.rx_byte), 64'h40);
    drive_frame(8'h41, 1'b1, 1'b0, 0, 1'b1);
    chk("par_good_out", 64'(bus.out), 64'b1011);
`endif

    // Random commands with random idle gaps (including none)
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom);
      rbad = 1'b0;
`ifdef UART_CMD_PARITY_EN
      rbad = ($urandom_range(0, 5) == 0);
`endif
      drive_frame(rd, 1'b1, rbad, 0, !rbad);
      repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
    end

    repeat (2 * CPB) @(negedge clk);
    chk("final_valid_count", 64'(n_valid), 64'(exp_valid));
    chk("final_ferr_count", 64'(n_ferr), 64'(exp_ferr));
    chk("final_perr_count", 64'(n_perr), 64'(exp_perr));
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
